// File: rtl/shared_adder_arbiter.sv
// Round-robin front-end sharing one adder among NUM_REQ requesters.
// The sum lands in a single registered result slot that holds under back-pressure.
module shared_adder_arbiter #(
    parameter int DATA_SIZE = 32,
    parameter int NUM_REQ   = 4,
    parameter int ID_SIZE   = 2   // must equal $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_a,
    input  logic [NUM_REQ*DATA_SIZE-1:0] req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [DATA_SIZE-1:0]         res_data,
    output logic                         res_carry,
    output logic [ID_SIZE-1:0]           res_id,
    output logic [15:0]                  op_count,
    output logic                         dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits on ready, and ready is combinational from valid and slot state only.

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    localparam int                 IW       = ID_SIZE + 1;
    localparam logic [ID_SIZE-1:0] LAST_RST = ID_SIZE'(NUM_REQ - 1);

    slot_state_t          state, state_next;
    logic [ID_SIZE-1:0]   last;
    logic [ID_SIZE-1:0]   winner;
    logic                 found;
    logic                 accept;
    logic                 grant;
    logic [DATA_SIZE-1:0] a_arr [NUM_REQ];
    logic [DATA_SIZE-1:0] b_arr [NUM_REQ];
    logic [DATA_SIZE-1:0] win_a, win_b;
    logic [DATA_SIZE:0]   sum;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_SIZE +: DATA_SIZE];
        assign b_arr[i] = req_b[i*DATA_SIZE +: DATA_SIZE];
    end

    assign res_valid = (state == FULL);
    assign dbg_state = state;
    assign accept    = ~res_valid | res_ready;

    // Scan starts just past the last winner and wraps around to it last.
    always_comb begin : pick
        logic [IW-1:0] idx_w;
        logic [ID_SIZE-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx_w  = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_w = {1'b0, last} + IW'(k);
            if (idx_w >= IW'(NUM_REQ)) begin
                idx_w = idx_w - IW'(NUM_REQ);
            end
            idx = idx_w[ID_SIZE-1:0];
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign grant = accept & found & rst_n;

    always_comb begin
        req_ready = '0;
        if (grant) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign win_a = a_arr[winner];
    assign win_b = b_arr[winner];
    assign sum   = {1'b0, win_a} + {1'b0, win_b};

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (grant) state_next = FULL;
            FULL: begin
                if (grant)          state_next = FULL;
                else if (res_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_data  <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            last      <= LAST_RST;
            op_count  <= 16'd0;
        end else if (grant) begin
            res_data  <= sum[DATA_SIZE-1:0];
            res_carry <= sum[DATA_SIZE];
            res_id    <= winner;
            last      <= winner;
            op_count  <= op_count + 16'd1;
        end
    end

endmodule

// File: doc/shared_adder_arbiter.md
# shared_adder_arbiter

Arbitrated front-end that shares one DATA_SIZE-bit adder datapath between NUM_REQ requesters in the MIPS core, e.g. PC+4, branch-target and address-generation users. It performs round-robin arbitration with a valid/ready handshake on each request port. The winning operands feed the shared adder, and the sum is registered into a single output slot that is held under back-pressure. The block sustains one operation per cycle when the consumer is ready.

## Interface
- DATA_SIZE, 32, operand and sum width
- NUM_REQ, 4, number of requesters (legal 2..8)
- ID_SIZE, 2, requester-ID width; must equal clog2(NUM_REQ)
- CLK  input  1  single clock, all state on rising edge
- RST  input  1  reset, asynchronous, active-low
- REQ_VALID  input  NUM_REQ  per-requester request valid
- REQ_READY  output  NUM_REQ  per-requester grant; a handshake occurs when VALID and READY are both high at a rising edge
- REQ_A  input  NUM_REQ*DATA_SIZE  operand A, requester i in bits [i*DATA_SIZE +: DATA_SIZE]
- REQ_B  input  NUM_REQ*DATA_SIZE  operand B, same packing
- RES_VALID  output  1  result slot full
- RES_READY  input  1  consumer accepts result
- RES_DATA  output  DATA_SIZE  registered A+B, modulo 2^DATA_SIZE
- RES_CARRY  output  1  carry-out of A+B
- RES_ID  output  ID_SIZE  index of the requester that produced RES_DATA
- OP_COUNT  output  16  count of accepted requests; wraps 0xFFFF→0x0000

## Operation
- State: result slot (RES_VALID, RES_DATA, RES_CARRY, RES_ID), round-robin pointer LAST (ID_SIZE bits, index of last winner), OP_COUNT.
- Slot FSM has two states:
  - EMPTY (RES_VALID=0).
  - FULL (RES_VALID=1).
- Slot transitions:
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on RES_READY with no grant.
  - FULL→FULL when a grant occurs in the same cycle as RES_READY; the slot is reloaded.
  - FULL→FULL with the slot unchanged when RES_READY=0.
- Define ACCEPT = ~RES_VALID | RES_READY.
- WINNER is the first i with REQ_VALID[i]=1, scanning LAST+1, LAST+2, … modulo NUM_REQ and ending with LAST itself.
- REQ_READY[i] = ACCEPT & REQ_VALID[i] & (i==WINNER), all combinational.
  - At most one bit is high.
  - All bits are zero when no request is valid or ACCEPT=0.
- On a grant:
  - {RES_CARRY, RES_DATA} ← zero-extended A + zero-extended B of the winner (DATA_SIZE+1-bit sum).
  - RES_ID ← WINNER, LAST ← WINNER, RES_VALID ← 1.
  - OP_COUNT increments by 1.
- With no grant, LAST and OP_COUNT hold.
- Requesters must hold REQ_A/REQ_B stable while VALID is high and READY is low. VALID may not be withdrawn before the handshake. The block does not check this.
- Non-winning requesters are not disturbed. Their requests stay pending; there is no starvation, since a continuously valid request is served within NUM_REQ grants.
- Outputs are a pure function of registered state plus the combinational REQ_READY path. REQ_READY depends on REQ_VALID, RES_VALID and RES_READY, and never on the operand inputs.
- Reset values:
  - RES_VALID=0, RES_DATA=0, RES_CARRY=0, RES_ID=0, OP_COUNT=0.
  - LAST=NUM_REQ-1, so requester 0 has first priority.
  - REQ_READY=0 while RST is low.

## Timing
- Latency: handshake at edge N → RES_VALID=1 with the result visible after edge N, i.e. in cycle N+1.
- Throughput: one grant per cycle while RES_READY=1 or the slot is empty.
- Back-pressure: while RES_VALID=1 and RES_READY=0:
  - RES_* are stable.
  - All REQ_READY bits are 0.
  - LAST and OP_COUNT are frozen.
- Simultaneous drain and grant: the old result is consumed and the new result is loaded on the same edge, with no bubble.
- Reset asserted mid-operation:
  - All state clears immediately and asynchronously; a pending result is discarded and not replayed.
  - REQ_READY drops at once.
  - The first edge after RST deasserts may grant.
- OP_COUNT wrap: 0xFFFF + one grant → 0x0000 with no flag.

## Test plan
- Single request: REQ_VALID=0001, A0=5, B0=7, RES_READY=1 → REQ_READY=0001 in the same cycle; the next cycle shows RES_VALID=1, RES_DATA=12, RES_CARRY=0, RES_ID=0, OP_COUNT=1.
- Overflow: A1=0xFFFFFFFF, B1=0x00000001 → RES_DATA=0x00000000, RES_CARRY=1, RES_ID=1.
- Full contention: REQ_VALID=1111 held, RES_READY=1 from reset → grants 0,1,2,3,0,1 on consecutive cycles; RES_VALID stays high continuously after the first; OP_COUNT=6 after six cycles.
- Back-pressure: slot full with RES_ID=2, RES_READY=0 for 3 cycles with REQ_VALID=1111 → RES_* constant, REQ_READY=0000, OP_COUNT unchanged; on RES_READY=1, REQ_READY=1000 in that same cycle.
- Skip fairness: LAST=1, REQ_VALID=1001 → grant 3, then grant 0, then grant 3 (with requester 1 and 2 idle).
- Reset mid-operation: RES_VALID=1 and OP_COUNT=0x0005, then pulse RST low between edges → RES_VALID=0 and OP_COUNT=0 immediately; after release with REQ_VALID=1111, the first grant goes to requester 0.
